fpu_issue_arbiter: RTL

FPU_ISSUE_ARBITER -- requirements
Module: fpu_issue_arbiter

---
 rtl/fpu_issue_arbiter.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fpu_issue_arbiter.sv
// Two-requester round-robin issue arbiter in front of a single FPU datapath.
// Accepts one operation at a time and returns the result or a timeout response.
module fpu_issue_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_op,
    input  logic [2:0]  req0_rm,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_rs2_lsb,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_op,
    input  logic [2:0]  req1_rm,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_rs2_lsb,
    output logic        fpu_start,
    output logic [4:0]  fpu_op,
    output logic [2:0]  fpu_rm,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic        fpu_rs2_lsb,
    input  logic [31:0] fpu_result,
    input  logic        fpu_done,
    input  logic        fpu_invalid,
    input  logic        fpu_div_by_zero,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    input  logic        fpu_inexact,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [4:0]  rsp_flags,
    output logic        rsp_timeout,
    output logic [4:0]  fflags,
    input  logic        fflags_clr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] CANON_NAN    = 32'h7FC0_0000;

    state_t      state_r;
    state_t      state_s;
    logic        rr_r;
    logic [7:0]  cnt_r;
    logic        id_r;
    logic        fpu_start_r;
    logic [4:0]  op_r;
    logic [2:0]  rm_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        rs2_lsb_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_result_r;
    logic [4:0]  rsp_flags_r;
    logic        rsp_timeout_r;
    logic [4:0]  fflags_r;

    logic        grant_s;
    logic        ready0_s;
    logic        ready1_s;
    logic        accept_s;
    logic        done_take_s;
    logic        timeout_s;
    logic        rsp_hs_s;

    // Grant selection: a lone requester wins, contention is settled by rr_r.
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = rr_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign ready0_s    = (state_r == IDLE) && req0_valid && !grant_s;
    assign ready1_s    = (state_r == IDLE) && req1_valid && grant_s;
    assign accept_s    = ready0_s || ready1_s;
    assign done_take_s = (state_r == WAIT) && fpu_done;
    assign timeout_s   = (state_r == WAIT) && !fpu_done && (cnt_r == TIMEOUT_LAST);
    assign rsp_hs_s    = (state_r == RESP) && rsp_ready;

    // Next-state logic; done has priority over the terminal timeout cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (done_take_s || timeout_s) begin
                    state_s = RESP;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register plus the start pulse and response-valid flags derived from it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            fpu_start_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            fpu_start_r <= accept_s;
            rsp_valid_r <= (state_s == RESP);
        end
    end

    // Round-robin pointer moves to the loser on every accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_r <= 1'b0;
        end else if (accept_s) begin
            rr_r <= ~grant_s;
        end else begin
            rr_r <= rr_r;
        end
    end

    // Operation capture on accept; fields then hold until the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_r      <= 1'b0;
            op_r      <= 5'd0;
            rm_r      <= 3'd0;
            a_r       <= 32'd0;
            b_r       <= 32'd0;
            rs2_lsb_r <= 1'b0;
        end else if (accept_s) begin
            id_r      <= grant_s;
            op_r      <= grant_s ? req1_op      : req0_op;
            rm_r      <= grant_s ? req1_rm      : req0_rm;
            a_r       <= grant_s ? req1_a       : req0_a;
            b_r       <= grant_s ? req1_b       : req0_b;
            rs2_lsb_r <= grant_s ? req1_rs2_lsb : req0_rs2_lsb;
        end else begin
            id_r      <= id_r;
            op_r      <= op_r;
            rm_r      <= rm_r;
            a_r       <= a_r;
            b_r       <= b_r;
            rs2_lsb_r <= rs2_lsb_r;
        end
    end

    // WAIT cycle counter, zero whenever the FSM is outside WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 8'd0;
        end else if (state_r == WAIT) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= 8'd0;
        end
    end

    // Response capture: FPU result or canonical-NaN timeout response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_result_r  <= 32'd0;
            rsp_flags_r   <= 5'd0;
            rsp_timeout_r <= 1'b0;
        end else if (done_take_s) begin
            rsp_result_r  <= fpu_result;
            rsp_flags_r   <= {fpu_invalid, fpu_div_by_zero, fpu_overflow, fpu_underflow, fpu_inexact};
            rsp_timeout_r <= 1'b0;
        end else if (timeout_s) begin
            rsp_result_r  <= CANON_NAN;
            rsp_flags_r   <= 5'b10000;
            rsp_timeout_r <= 1'b1;
        end else begin
            rsp_result_r  <= rsp_result_r;
            rsp_flags_r   <= rsp_flags_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    // Sticky exception flags; a clear coinciding with a delivery keeps only the new flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fflags_r <= 5'd0;
        end else if (rsp_hs_s && fflags_clr) begin
            fflags_r <= rsp_flags_r;
        end else if (rsp_hs_s) begin
            fflags_r <= fflags_r | rsp_flags_r;
        end else if (fflags_clr) begin
            fflags_r <= 5'd0;
        end else begin
            fflags_r <= fflags_r;
        end
    end

    assign req0_ready  = ready0_s;
    assign req1_ready  = ready1_s;
    assign fpu_start   = fpu_start_r;
    assign fpu_op      = op_r;
    assign fpu_rm      = rm_r;
    assign fpu_a       = a_r;
    assign fpu_b       = b_r;
    assign fpu_rs2_lsb = rs2_lsb_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_id      = id_r;
    assign rsp_result  = rsp_result_r;
    assign rsp_flags   = rsp_flags_r;
    assign rsp_timeout = rsp_timeout_r;
    assign fflags      = fflags_r;

endmodule
